// File: rtl/overcooked_pkg.sv
// Shared types and widths for the order board sequencer.
package overcooked_pkg;

    typedef logic [3:0] dish_t;

    localparam dish_t DISH_NONE      = 4'd0;
    localparam int    NUM_ORDERS_DEF = 4;
    localparam int    TIME_W         = 5;
    localparam int    SCORE_W        = 10;
    localparam int    SCORE_MAX      = (1 << SCORE_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/order_scheduler_if.sv
// Control, serve and board-display signals of the order scheduler.
interface order_scheduler_if
    import overcooked_pkg::*;
#(
    parameter int NUM_ORDERS = NUM_ORDERS_DEF
);
    logic                                start;
    logic                                pause;
    logic                                stop;
    logic                                tick;
    logic [1:0]                          serve_req;
    dish_t [1:0]                         serve_dish;
    logic [NUM_ORDERS-1:0]               orders;
    dish_t [NUM_ORDERS-1:0]              order_dishes;
    logic [NUM_ORDERS-1:0][TIME_W-1:0]   order_times;
    logic [SCORE_W-1:0]                  point_total;
    logic [1:0]                          serve_ack;
    logic [1:0]                          serve_nack;
    logic                                running;

    modport master (
        output start, pause, stop, tick, serve_req, serve_dish,
        input  orders, order_dishes, order_times, point_total,
               serve_ack, serve_nack, running
    );

    modport slave (
        input  start, pause, stop, tick, serve_req, serve_dish,
        output orders, order_dishes, order_times, point_total,
               serve_ack, serve_nack, running
    );
endinterface

// File: rtl/order_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4) used to pick spawned dishes.
module order_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] value
);
    logic [7:0] lfsr_q, lfsr_d;

    // Shift in the tap parity only while enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Seed on reset; the seed must be nonzero or the sequence locks up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;
endmodule

// File: rtl/order_scheduler.sv
// Order board sequencer: spawns orders, ages them on the game tick,
// arbitrates the two serving counters and keeps the score.
module order_scheduler
    import overcooked_pkg::*;
#(
    parameter int         NUM_ORDERS     = NUM_ORDERS_DEF,
    parameter int         NUM_DISHES     = 3,
    parameter int         ORDER_TIME     = 20,
    parameter int         SPAWN_INTERVAL = 8,
    parameter int         POINTS_BASE    = 20,
    parameter int         PENALTY        = 10,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    order_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_ORDERS > 1) ? $clog2(NUM_ORDERS) : 1;
    localparam int CNT_W = $clog2(SPAWN_INTERVAL + 1);
    localparam int SUM_W = SCORE_W + 2;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    sched_state_t                      state_q, state_d;
    logic [NUM_ORDERS-1:0]             valid_q, valid_d;
    dish_t [NUM_ORDERS-1:0]            dish_q, dish_d;
    logic [NUM_ORDERS-1:0][TIME_W-1:0] time_q, time_d;
    logic [SCORE_W-1:0]                score_q, score_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              pend_q, pend_d;
    logic                              rr_q, rr_d;
    logic                              running_q, running_d;
    logic [1:0]                        ack_q, ack_d, nack_q, nack_d;

    logic [7:0]            lfsr_val;
    logic                  lfsr_en;
    logic                  run_active;
    dish_t                 spawn_dish;
    logic [7:0]            dish_mod;
    pick_t                 pick0, pick1, pick_alt;
    logic [NUM_ORDERS-1:0] excl_mask;
    logic                  contend;
    logic [1:0]            grant;
    logic [IDX_W-1:0]      gidx0, gidx1;
    logic [NUM_ORDERS-1:0] served;
    int                    pen_cnt;
    logic                  free_found, fill, wrap;
    logic [IDX_W-1:0]      free_idx;
    logic [SUM_W-1:0]      gain, up, pen;

    assign lfsr_en    = (state_q == ST_RUN);
    assign run_active = (state_q == ST_RUN) && !bus.start;

    order_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .value (lfsr_val)
    );

    // Open slot holding the wanted dish with the least time left; ties keep the lowest index.
    function automatic pick_t find_best(input dish_t want, input logic [NUM_ORDERS-1:0] excl);
        pick_t            p;
        logic [TIME_W-1:0] best_t;
        p      = '0;
        best_t = '1;
        for (int i = 0; i < NUM_ORDERS; i++) begin
            if (valid_q[i] && !excl[i] && want != DISH_NONE && dish_q[i] == want &&
                (!p.found || time_q[i] < best_t)) begin
                p.found = 1'b1;
                p.idx   = IDX_W'(i);
                best_t  = time_q[i];
            end
        end
        return p;
    endfunction

    // Serve arbitration: when both counters target the same best slot the
    // round-robin winner takes it and the loser falls back to the next candidate.
    always_comb begin
        pick0     = find_best(bus.serve_dish[0], '0);
        pick1     = find_best(bus.serve_dish[1], '0);
        excl_mask = NUM_ORDERS'(1) << pick0.idx;
        pick_alt  = find_best(bus.serve_dish[0], excl_mask);
        contend   = run_active && (&bus.serve_req) && pick0.found && pick1.found &&
                    (pick0.idx == pick1.idx);
        grant     = 2'b00;
        gidx0     = pick0.idx;
        gidx1     = pick1.idx;
        if (run_active) begin
            grant[0] = bus.serve_req[0] && pick0.found;
            grant[1] = bus.serve_req[1] && pick1.found;
            if (contend) begin
                if (!rr_q) begin
                    grant[1] = pick_alt.found;
                    gidx1    = pick_alt.idx;
                end else begin
                    grant[0] = pick_alt.found;
                    gidx0    = pick_alt.idx;
                end
            end
        end
        served = '0;
        if (grant[0]) served = served | (NUM_ORDERS'(1) << gidx0);
        if (grant[1]) served = served | (NUM_ORDERS'(1) << gidx1);
    end

    // Next-state for the FSM, board, spawn logic and score.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dish_d     = dish_q;
        time_d     = time_q;
        score_d    = score_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        rr_d       = rr_q;
        ack_d      = grant;
        nack_d     = bus.serve_req & ~grant;
        pen_cnt    = 0;
        free_found = 1'b0;
        free_idx   = '0;
        fill       = 1'b0;
        wrap       = 1'b0;
        gain       = '0;
        up         = '0;
        pen        = '0;
        dish_mod   = lfsr_val % 8'(NUM_DISHES);
        spawn_dish = dish_mod[3:0] + 4'd1;

        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.start)      state_d = ST_RUN;
                else if (bus.stop)  state_d = ST_IDLE;
                else if (bus.pause) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.start)       state_d = ST_RUN;
                else if (bus.stop)   state_d = ST_IDLE;
                else if (!bus.pause) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase

        if (bus.start) begin
            valid_d = '0;
            dish_d  = '0;
            time_d  = '0;
            score_d = '0;
            cnt_d   = '0;
            pend_d  = 1'b1;
        end else if (run_active) begin
            if (contend) rr_d = ~rr_q;

            // A serve beats an expiry on the same slot and is scored on pre-tick time.
            for (int i = 0; i < NUM_ORDERS; i++) begin
                if (served[i]) begin
                    valid_d[i] = 1'b0;
                    dish_d[i]  = DISH_NONE;
                    time_d[i]  = '0;
                end else if (valid_q[i] && bus.tick) begin
                    if (time_q[i] == TIME_W'(1)) begin
                        valid_d[i] = 1'b0;
                        dish_d[i]  = DISH_NONE;
                        time_d[i]  = '0;
                        pen_cnt++;
                    end else begin
                        time_d[i] = time_q[i] - TIME_W'(1);
                    end
                end
            end

            if (bus.tick) begin
                if (cnt_q == CNT_W'(SPAWN_INTERVAL - 1)) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Slots freed this cycle only become available on the next one.
            for (int i = NUM_ORDERS - 1; i >= 0; i--) begin
                if (!valid_q[i]) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(i);
                end
            end
            fill = pend_q && free_found;
            if (fill) begin
                valid_d[free_idx] = 1'b1;
                dish_d[free_idx]  = spawn_dish;
                time_d[free_idx]  = TIME_W'(ORDER_TIME);
            end
            pend_d = (pend_q && !fill) || wrap;

            if (grant[0]) gain = gain + SUM_W'(POINTS_BASE) + SUM_W'(time_q[gidx0]);
            if (grant[1]) gain = gain + SUM_W'(POINTS_BASE) + SUM_W'(time_q[gidx1]);
            up = SUM_W'(score_q) + gain;
            if (up > SUM_W'(SCORE_MAX)) up = SUM_W'(SCORE_MAX);
            pen     = SUM_W'(pen_cnt * PENALTY);
            score_d = (up >= pen) ? SCORE_W'(up - pen) : '0;
        end

        running_d = (state_d == ST_RUN);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            valid_q   <= '0;
            dish_q    <= '0;
            time_q    <= '0;
            score_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            rr_q      <= 1'b0;
            running_q <= 1'b0;
            ack_q     <= 2'b00;
            nack_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            dish_q    <= dish_d;
            time_q    <= time_d;
            score_q   <= score_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            running_q <= running_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
        end
    end

    assign bus.orders       = valid_q;
    assign bus.order_dishes = dish_q;
    assign bus.order_times  = time_q;
    assign bus.point_total  = score_q;
    assign bus.serve_ack    = ack_q;
    assign bus.serve_nack   = nack_q;
    assign bus.running      = running_q;
endmodule

// File: tb/tb_order_scheduler.sv
// Directed bench for order_scheduler: serve responses go through a scoreboard
// queue checked by a monitor; board and score are checked inline.
module tb_order_scheduler;
    import overcooked_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    order_scheduler_if #(.NUM_ORDERS(4)) bus ();

    // Spawn interval shortened so the board can fill before the first expiry.
    order_scheduler #(.SPAWN_INTERVAL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_srv = 0;
    logic [3:0] exp_q [$];   // {ack[1:0], nack[1:0]}
    logic [3:0] mon_exp;

    // Monitor: every serve response is popped against the next expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.serve_ack != 2'b00 || bus.serve_nack != 2'b00)) begin
            n_cmp++;
            n_srv++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL serve_unexpected: got ack=%b nack=%b, required no response",
                         bus.serve_ack, bus.serve_nack);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.serve_ack, bus.serve_nack} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL serve_resp #%0d: got ack=%b nack=%b, required ack=%b nack=%b",
                             n_srv, bus.serve_ack, bus.serve_nack, mon_exp[3:2], mon_exp[1:0]);
                end else begin
                    $display("serve #%0d: ack=%b nack=%b as required",
                             n_srv, bus.serve_ack, bus.serve_nack);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end else begin
            $display("check %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
            step();
        end
    endtask

    task automatic serve(input logic [1:0] req, input dish_t d0, input dish_t d1,
                         input logic [1:0] ack, input logic [1:0] nack);
        exp_q.push_back({ack, nack});
        bus.serve_req     = req;
        bus.serve_dish[0] = d0;
        bus.serve_dish[1] = d1;
        step();
        bus.serve_req     = 2'b00;
        bus.serve_dish[0] = DISH_NONE;
        bus.serve_dish[1] = DISH_NONE;
    endtask

    task automatic clear_inputs();
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.stop       = 1'b0;
        bus.tick       = 1'b0;
        bus.serve_req  = 2'b00;
        bus.serve_dish = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
    endtask

    initial begin
        dish_t d;
        dish_t e;

        // Reset values
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        chk("rst_orders", 32'(bus.orders), 0);
        chk("rst_times", 32'(bus.order_times), 0);
        chk("rst_dishes", 32'(bus.order_dishes), 0);
        chk("rst_score", 32'(bus.point_total), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_acknack", 32'({bus.serve_ack, bus.serve_nack}), 0);
        rst_n = 1'b1;
        step();

        // First spawn, serve, refill on full board, expiry penalty
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("a_running_after_start", 32'(bus.running), 1);
        chk("a_no_slot_yet", 32'(bus.orders), 0);
        step();
        chk("a_orders_first", 32'(bus.orders), 32'h1);
        chk("a_time0_first", 32'(bus.order_times[0]), 20);
        chk("a_dish0_first", 32'(bus.order_dishes[0]), 1);
        chk("a_score_first", 32'(bus.point_total), 0);
        serve(2'b01, 4'd1, DISH_NONE, 2'b01, 2'b00);
        chk("a_orders_served", 32'(bus.orders), 0);
        chk("a_score_40", 32'(bus.point_total), 40);
        serve(2'b10, DISH_NONE, DISH_NONE, 2'b00, 2'b10);
        serve(2'b01, 4'd2, DISH_NONE, 2'b00, 2'b01);
        ticks(4);
        chk("a_respawn_orders", 32'(bus.orders), 32'h1);
        chk("a_respawn_time", 32'(bus.order_times[0]), 20);
        ticks(16);
        chk("a_full_orders", 32'(bus.orders), 32'hF);
        chk("a_full_time0", 32'(bus.order_times[0]), 4);
        chk("a_full_time1", 32'(bus.order_times[1]), 8);
        chk("a_full_time2", 32'(bus.order_times[2]), 12);
        chk("a_full_time3", 32'(bus.order_times[3]), 16);
        d = bus.order_dishes[0];
        serve(2'b01, d, DISH_NONE, 2'b01, 2'b00);
        chk("a_freed_orders", 32'(bus.orders), 32'hE);
        chk("a_score_64", 32'(bus.point_total), 64);
        step();
        chk("a_refill_orders", 32'(bus.orders), 32'hF);
        chk("a_refill_time0", 32'(bus.order_times[0]), 20);
        ticks(8);
        chk("a_expire_score", 32'(bus.point_total), 54);
        chk("a_expire_orders", 32'(bus.orders), 32'hF);
        chk("a_expire_time0", 32'(bus.order_times[0]), 12);
        chk("a_expire_time1", 32'(bus.order_times[1]), 20);
        chk("a_expire_time2", 32'(bus.order_times[2]), 4);
        chk("a_expire_time3", 32'(bus.order_times[3]), 8);

        // Asynchronous reset mid-game, then expiry at score 0 (floor)
        rst_n = 1'b0;
        #2;
        chk("b_async_orders", 32'(bus.orders), 0);
        chk("b_async_score", 32'(bus.point_total), 0);
        chk("b_async_running", 32'(bus.running), 0);
        do_reset();
        do_start();
        chk("b_orders_first", 32'(bus.orders), 32'h1);
        chk("b_dish0_first", 32'(bus.order_dishes[0]), 1);
        ticks(1);
        chk("b_time0_19", 32'(bus.order_times[0]), 19);
        ticks(18);
        chk("b_pre_expire_orders", 32'(bus.orders), 32'hF);
        chk("b_pre_expire_time0", 32'(bus.order_times[0]), 1);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("b_expired_orders", 32'(bus.orders), 32'hE);
        chk("b_expired_time0", 32'(bus.order_times[0]), 0);
        chk("b_expired_dish0", 32'(bus.order_dishes[0]), 0);
        chk("b_floor_score", 32'(bus.point_total), 0);
        step();
        chk("b_refill_orders", 32'(bus.orders), 32'hF);
        chk("b_refill_time0", 32'(bus.order_times[0]), 20);
        chk("b_time1", 32'(bus.order_times[1]), 4);
        chk("b_time2", 32'(bus.order_times[2]), 8);
        chk("b_time3", 32'(bus.order_times[3]), 12);

        // Contention between the two counters
        do_reset();
        do_start();
        chk("c_orders_first", 32'(bus.orders), 32'h1);
        serve(2'b11, 4'd1, 4'd1, 2'b01, 2'b10);
        chk("c_score_40", 32'(bus.point_total), 40);
        chk("c_orders_empty", 32'(bus.orders), 0);
        ticks(4);
        chk("c_orders_spawn", 32'(bus.orders), 32'h1);
        d = bus.order_dishes[0];
        serve(2'b11, d, d, 2'b10, 2'b01);
        chk("c_score_80", 32'(bus.point_total), 80);
        ticks(8);
        chk("c_two_orders", 32'(bus.orders), 32'h3);
        chk("c_two_time0", 32'(bus.order_times[0]), 16);
        chk("c_two_time1", 32'(bus.order_times[1]), 20);
        d = bus.order_dishes[0];
        e = bus.order_dishes[1];
        serve(2'b11, d, e, 2'b11, 2'b00);
        chk("c_score_156", 32'(bus.point_total), 156);
        chk("c_orders_cleared", 32'(bus.orders), 0);

        // Pause freezes the board, serve in pause/idle nacks, stop holds score
        ticks(5);
        chk("d_orders", 32'(bus.orders), 32'h1);
        chk("d_time0_19", 32'(bus.order_times[0]), 19);
        bus.pause = 1'b1;
        step();
        chk("d_paused_running", 32'(bus.running), 0);
        ticks(5);
        chk("d_paused_time0", 32'(bus.order_times[0]), 19);
        d = bus.order_dishes[0];
        serve(2'b01, d, DISH_NONE, 2'b00, 2'b01);
        chk("d_paused_orders", 32'(bus.orders), 32'h1);
        chk("d_paused_score", 32'(bus.point_total), 156);
        bus.pause = 1'b0;
        step();
        chk("d_resumed_running", 32'(bus.running), 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("d_stopped_running", 32'(bus.running), 0);
        chk("d_stopped_score", 32'(bus.point_total), 156);
        chk("d_stopped_orders", 32'(bus.orders), 32'h1);
        ticks(2);
        chk("d_idle_time0", 32'(bus.order_times[0]), 19);
        serve(2'b01, d, DISH_NONE, 2'b00, 2'b01);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("d_start_wins_running", 32'(bus.running), 1);
        chk("d_start_wins_orders", 32'(bus.orders), 0);
        chk("d_start_wins_score", 32'(bus.point_total), 0);
        step();
        chk("d_restart_spawn", 32'(bus.orders), 32'h1);
        step();
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/order_scheduler.md
# order_scheduler

Sequencer for the customer-order board. Spawns dish orders into a fixed set of slots, counts their deadlines down on a one-second tick, arbitrates serve attempts from the two serving counters against the open orders, and keeps the running score. Sits between the counter/plate logic upstream and the HUD/order-display renderer downstream; it owns every order and point register in the game.

## Interface
- NUM_ORDERS, 4, number of order slots
- NUM_DISHES, 3, valid dish codes are 1..NUM_DISHES; code 0 = no dish
- ORDER_TIME, 20, initial deadline in ticks (must be ≤ 31)
- SPAWN_INTERVAL, 8, ticks between spawns
- POINTS_BASE, 20, points per served order
- PENALTY, 10, points lost per expired order
- LFSR_SEED, 8'hA5, nonzero LFSR reset value

- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse: IDLE→RUN, clears board and score
- pause  in  1  level: RUN↔PAUSE
- stop  in  1  pulse: any state→IDLE, score held
- tick  in  1  one-cycle pulse, 1 Hz game time
- serve_req  in  2  per-counter serve pulse
- serve_dish  in  [1:0][3:0]  dish code on each counter, sampled with serve_req
- orders  out  [NUM_ORDERS-1:0]  slot valid
- order_dishes  out  [NUM_ORDERS-1:0][3:0]  dish per slot, 0 when invalid
- order_times  out  [NUM_ORDERS-1:0][4:0]  remaining ticks, 0 when invalid
- point_total  out  10  score
- serve_ack / serve_nack  out  2 each  one-cycle result pulse per counter
- running  out  1  high in RUN

## Operation
- States: IDLE, RUN, PAUSE. IDLE→RUN on start (wins over stop same cycle: stop ignored). RUN→PAUSE while pause=1; PAUSE→RUN when pause=0. RUN/PAUSE→IDLE on stop. start in RUN/PAUSE restarts (same as IDLE→RUN).
- On start: all slots cleared, point_total=0, spawn counter=0, spawn pending set so slot 0 fills on the next clock.
- Tick in RUN: every valid slot decrements order_times. Slot at 1 that ticks becomes invalid (expiry); point_total -= PENALTY, floored at 0. Multiple expiries same tick: penalties summed, floored once.
- Spawn: counter increments per tick in RUN; at SPAWN_INTERVAL it resets and sets spawn pending. Pending + free slot: lowest free slot gets dish (lfsr % NUM_DISHES)+1, time ORDER_TIME, pending cleared. Board full: pending held until a slot frees.
- Serve in RUN: request matches the valid slot with same dish and smallest order_times, ties → lowest index. Match: slot invalidated, point_total += POINTS_BASE + remaining time, saturating at 1023, serve_ack. No match or dish 0: serve_nack.
- Both counters same cycle: if distinct slots available both ack. If they contend for the single eligible slot, round-robin pointer picks winner (reset: counter 0 first), loser nacks; pointer flips after each contended grant.
- Serve/expiry same slot same cycle: serve wins, scored on pre-decrement time, no penalty.
- Serve in IDLE/PAUSE: nack. Tick and spawn ignored in IDLE/PAUSE; board frozen in PAUSE, cleared-to-hold in IDLE (values retained, running=0).
- LFSR: 8-bit maximal (taps 8,6,5,4), advances every clock in RUN.

## Timing
- Reset: all outputs 0, state IDLE, lfsr=LFSR_SEED, rr pointer=0.
- All outputs registered. serve_ack/nack one cycle after serve_req. Tick effects visible the cycle after tick. Slot 0 visible the second cycle after start.
- Spawn and serve same cycle: serve evaluated on current board; spawn uses free slots after serve frees nothing until next cycle (freed slot reusable next cycle).
- Reset mid-game: immediate asynchronous clear to reset values.

## Structure
- overcooked_pkg: dish_t (logic [3:0]), DISH_NONE, NUM_ORDERS default, sched_state_t enum, score width.
- Sub-module order_lfsr (8-bit LFSR with enable and seed).

## Test plan
- Reset then start, 1 clock idle → orders=4'b0001, order_times[0]=20, point_total=0, running=1.
- Serve dish of slot 0 at time 20 → serve_ack[0] next cycle, orders=0, point_total=40.
- No serve for 20 ticks → slot 0 expires, point_total stays 0 (floor); from score 40 → 30.
- Both counters serve same dish, one eligible slot → ack[0]/nack[1]; repeat contention → ack[1]/nack[0].
- Fill all 4 slots, 8 more ticks → no spawn; serve one → lowest free slot refilled next cycle with time 20.
- Pause 5 ticks → order_times unchanged; serve during pause → nack; stop → running=0, score held.
